// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the core run-control sequencer: controller states and run status codes.
package core_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BOOT  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_TIMEOUT    = 2'd1,
        ERR_ABORT      = 2'd2,
        ERR_MISALIGNED = 2'd3
    } run_err_t;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Host-side control/status bundle of the run-control sequencer plus the core-facing outputs.
interface core_run_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    import core_run_ctrl_pkg::*;

    logic             start;
    logic [WIDTH-1:0] start_pc;
    logic [CNT_W-1:0] cfg_timeout;
    logic             abort;
    logic             fin;
    logic             core_reset_n;
    logic [WIDTH-1:0] init_pc;
    logic             busy;
    logic             done;
    logic             fault;
    run_err_t         err_code;
    logic             irq;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output start, start_pc, cfg_timeout, abort, fin,
        input  core_reset_n, init_pc, busy, done, fault, err_code, irq, cycle_cnt
    );

    modport slave (
        input  start, start_pc, cfg_timeout, abort, fin,
        output core_reset_n, init_pc, busy, done, fault, err_code, irq, cycle_cnt
    );

endinterface

// File: rtl/core_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count register; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/core_run_ctrl.sv
// Run-control sequencer: holds the core in reset with init_pc, releases it, counts run cycles
// and stops it on ecall retirement, watchdog timeout or host abort.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    core_run_ctrl_if.slave bus
);

    localparam int            BW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(RST_CYCLES - 1);

    run_state_t       r_state;
    run_state_t       w_state_nxt;
    logic [BW-1:0]    r_boot_cnt;
    logic [BW-1:0]    w_boot_nxt;
    logic [CNT_W-1:0] r_timeout;
    logic [WIDTH-1:0] r_init_pc;
    run_err_t         r_err;
    run_err_t         w_err_nxt;
    logic             r_irq;
    logic             w_irq_nxt;
    logic             r_core_reset_n;
    logic             r_busy;
    logic             r_done;
    logic             r_fault;
    logic             w_accept;
    logic             w_cnt_en;
    logic             w_to_hit;
    logic [CNT_W-1:0] w_cnt;

    assign w_to_hit = (r_timeout != {CNT_W{1'b0}}) &&
                      (w_cnt == (r_timeout - {{(CNT_W-1){1'b0}}, 1'b1}));

    // Next-state, status and counter-control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_boot_nxt  = r_boot_cnt;
        w_err_nxt   = r_err;
        w_irq_nxt   = 1'b0;
        w_accept    = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            IDLE, DONE, FAULT: begin
                // start outranks abort here; abort is simply not looked at
                if (bus.start) begin
                    if (bus.start_pc[1:0] != 2'b00) begin
                        w_state_nxt = FAULT;
                        w_err_nxt   = ERR_MISALIGNED;
                        w_irq_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = BOOT;
                        w_err_nxt   = ERR_NONE;
                        w_boot_nxt  = {BW{1'b0}};
                        w_accept    = 1'b1;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            BOOT: begin
                if (bus.abort) begin
                    w_state_nxt = FAULT;
                    w_err_nxt   = ERR_ABORT;
                    w_irq_nxt   = 1'b1;
                end else if (r_boot_cnt == BOOT_LAST) begin
                    w_state_nxt = RUN;
                end else begin
                    w_boot_nxt = r_boot_cnt + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                // the exit cycle itself is counted
                w_cnt_en = 1'b1;
                if (bus.fin) begin
                    w_state_nxt = DONE;
                    w_irq_nxt   = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt = FAULT;
                    w_err_nxt   = ERR_TIMEOUT;
                    w_irq_nxt   = 1'b1;
                end else if (bus.abort) begin
                    w_state_nxt = FAULT;
                    w_err_nxt   = ERR_ABORT;
                    w_irq_nxt   = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, latched launch parameters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_boot_cnt     <= {BW{1'b0}};
            r_timeout      <= {CNT_W{1'b0}};
            r_init_pc      <= {WIDTH{1'b0}};
            r_err          <= ERR_NONE;
            r_irq          <= 1'b0;
            r_core_reset_n <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_boot_cnt     <= w_boot_nxt;
            r_err          <= w_err_nxt;
            r_irq          <= w_irq_nxt;
            r_core_reset_n <= (w_state_nxt == RUN);
            r_busy         <= (w_state_nxt == BOOT) || (w_state_nxt == RUN);
            r_done         <= (w_state_nxt == DONE);
            r_fault        <= (w_state_nxt == FAULT);
            if (w_accept) begin
                r_init_pc <= bus.start_pc;
                r_timeout <= bus.cfg_timeout;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_accept),
        .i_en  (w_cnt_en),
        .o_cnt (w_cnt)
    );

    assign bus.core_reset_n = r_core_reset_n;
    assign bus.init_pc      = r_init_pc;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.fault        = r_fault;
    assign bus.err_code     = r_err;
    assign bus.irq          = r_irq;
    assign bus.cycle_cnt    = w_cnt;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: a 32-bit counter instance and a 4-bit saturation instance.
module tb_core_run_ctrl;
    import core_run_ctrl_pkg::*;

    localparam int RST_CYCLES = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   k;

    core_run_ctrl_if #(.WIDTH(32), .CNT_W(32)) bus  ();
    core_run_ctrl_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

    core_run_ctrl #(.WIDTH(32), .CNT_W(32), .RST_CYCLES(RST_CYCLES)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    core_run_ctrl #(.WIDTH(32), .CNT_W(4), .RST_CYCLES(RST_CYCLES)) u_dut4 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-cycle start pulse; returns just after the accepting edge
    task automatic launch(input bit four, input logic [31:0] pc, input logic [31:0] to);
        if (four) begin
            bus4.start = 1'b1; bus4.start_pc = pc; bus4.cfg_timeout = to[3:0];
        end else begin
            bus.start = 1'b1; bus.start_pc = pc; bus.cfg_timeout = to;
        end
        step();
        bus.start  = 1'b0;
        bus4.start = 1'b0;
    endtask

    // edges from the accepting edge (inclusive) to core_reset_n rising, bounded
    task automatic wait_run(input bit four, input string tag);
        k = 1;
        while (((four ? bus4.core_reset_n : bus.core_reset_n) !== 1'b1) && (k < 40)) begin
            step();
            k++;
        end
        check(tag, 32'(k), 32'(RST_CYCLES + 1));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.start_pc = 32'h0; bus.cfg_timeout = 32'h0;
        bus.abort = 1'b0; bus.fin = 1'b0;
        bus4.start = 1'b0; bus4.start_pc = 32'h0; bus4.cfg_timeout = 4'h0;
        bus4.abort = 1'b0; bus4.fin = 1'b0;
        #1;
        check("rst_crn",  32'(bus.core_reset_n), 32'd0);
        check("rst_pc",   bus.init_pc, 32'h0);
        check("rst_stat", {28'd0, bus.busy, bus.done, bus.fault, bus.irq}, 32'h0);
        check("rst_err",  32'(bus.err_code), 32'(ERR_NONE));
        check("rst_cnt",  bus.cycle_cnt, 32'd0);
        step();
        step();
        #2 rst = 1'b0;
        step();

        // 1: normal run ending on fin in RUN cycle 20
        launch(1'b0, 32'h100, 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_crn0", 32'(bus.core_reset_n), 32'd0);
        check("t1_pc",   bus.init_pc, 32'h100);
        wait_run(1'b0, "t1_lat");
        repeat (19) step();
        check("t1_cnt19", bus.cycle_cnt, 32'd19);
        bus.fin = 1'b1;
        step();
        bus.fin = 1'b0;
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_irq",  32'(bus.irq), 32'd1);
        check("t1_cnt",  bus.cycle_cnt, 32'd20);
        check("t1_err",  32'(bus.err_code), 32'(ERR_NONE));
        check("t1_crn",  32'(bus.core_reset_n), 32'd0);
        check("t1_busy0", 32'(bus.busy), 32'd0);
        step();
        check("t1_irq0", 32'(bus.irq), 32'd0);
        check("t1_hold", 32'(bus.done), 32'd1);

        // 2: watchdog timeout after 50 RUN cycles
        launch(1'b0, 32'h200, 32'd50);
        wait_run(1'b0, "t2_lat");
        k = 0;
        while ((bus.fault !== 1'b1) && (k < 200)) begin
            step();
            k++;
        end
        check("t2_cycles", 32'(k), 32'd50);
        check("t2_err",  32'(bus.err_code), 32'(ERR_TIMEOUT));
        check("t2_cnt",  bus.cycle_cnt, 32'd50);
        check("t2_crn",  32'(bus.core_reset_n), 32'd0);
        check("t2_irq",  32'(bus.irq), 32'd1);

        // 3: misaligned entry PC faults immediately, no BOOT
        launch(1'b0, 32'h102, 32'd0);
        check("t3_fault", 32'(bus.fault), 32'd1);
        check("t3_err",   32'(bus.err_code), 32'(ERR_MISALIGNED));
        check("t3_irq",   32'(bus.irq), 32'd1);
        check("t3_busy",  32'(bus.busy), 32'd0);
        check("t3_cnt",   bus.cycle_cnt, 32'd50);
        check("t3_pc",    bus.init_pc, 32'h200);
        step();
        check("t3_crn",   32'(bus.core_reset_n), 32'd0);
        check("t3_irq0",  32'(bus.irq), 32'd0);
        check("t3_busy1", 32'(bus.busy), 32'd0);

        // 4a: fin, abort and timeout all due in one RUN cycle -> fin wins
        launch(1'b0, 32'h300, 32'd10);
        wait_run(1'b0, "t4_lat");
        repeat (9) step();
        check("t4_cnt9", bus.cycle_cnt, 32'd9);
        bus.fin = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.fin = 1'b0;
        bus.abort = 1'b0;
        check("t4_done",  32'(bus.done), 32'd1);
        check("t4_fault", 32'(bus.fault), 32'd0);
        check("t4_err",   32'(bus.err_code), 32'(ERR_NONE));
        check("t4_cnt",   bus.cycle_cnt, 32'd10);

        // 4b: abort in BOOT cycle 2
        launch(1'b0, 32'h400, 32'd0);
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t4b_fault", 32'(bus.fault), 32'd1);
        check("t4b_err",   32'(bus.err_code), 32'(ERR_ABORT));
        check("t4b_irq",   32'(bus.irq), 32'd1);
        check("t4b_crn",   32'(bus.core_reset_n), 32'd0);
        check("t4b_cnt",   bus.cycle_cnt, 32'd0);
        check("t4b_pc",    bus.init_pc, 32'h400);

        // 5: start during RUN ignored; restart from DONE clears count
        launch(1'b0, 32'h500, 32'd0);
        wait_run(1'b0, "t5_lat");
        repeat (4) step();
        launch(1'b0, 32'h600, 32'd3);
        check("t5_cnt",  bus.cycle_cnt, 32'd5);
        check("t5_busy", 32'(bus.busy), 32'd1);
        check("t5_pc",   bus.init_pc, 32'h500);
        check("t5_crn",  32'(bus.core_reset_n), 32'd1);
        bus.fin = 1'b1;
        step();
        bus.fin = 1'b0;
        check("t5_done", 32'(bus.done), 32'd1);
        check("t5_cnt6", bus.cycle_cnt, 32'd6);
        launch(1'b0, 32'h700, 32'd0);
        check("t5_rcnt", bus.cycle_cnt, 32'd0);
        check("t5_rpc",  bus.init_pc, 32'h700);
        check("t5_rdone", 32'(bus.done), 32'd0);

        // 6: asynchronous reset mid-RUN
        wait_run(1'b0, "t6_lat");
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        check("t6_crn",  32'(bus.core_reset_n), 32'd0);
        check("t6_stat", {28'd0, bus.busy, bus.done, bus.fault, bus.irq}, 32'h0);
        check("t6_cnt",  bus.cycle_cnt, 32'd0);
        check("t6_pc",   bus.init_pc, 32'h0);
        step();
        check("t6_irq",  32'(bus.irq), 32'd0);
        #2 rst = 1'b0;
        step();
        check("t6_idle", {28'd0, bus.busy, bus.done, bus.fault, bus.irq}, 32'h0);

        // 6b: 4-bit counter saturates at 15 over a 20-cycle run
        launch(1'b1, 32'h800, 32'd0);
        wait_run(1'b1, "t6b_lat");
        repeat (19) step();
        bus4.fin = 1'b1;
        step();
        bus4.fin = 1'b0;
        check("t6b_done", 32'(bus4.done), 32'd1);
        check("t6b_cnt",  32'(bus4.cycle_cnt), 32'd15);
        check("t6b_err",  32'(bus4.err_code), 32'(ERR_NONE));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
